// File: rtl/moore_stream_sched_pkg.sv
// rtl/moore_stream_sched_pkg.sv - shared types and constants for the Moore detector stimulus scheduler
package moore_stream_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_W = 8;
    localparam int TOT_W = 16;
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    // Increment that sticks at TOT_MAX instead of wrapping
    function automatic logic [TOT_W-1:0] sat_inc(input logic [TOT_W-1:0] v);
        return (v == TOT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/moore_stream_sched_hit_tally.sv
// rtl/moore_stream_sched_hit_tally.sv - attributes detector hits to word bits, per-word count and running total
module moore_stream_sched_hit_tally
    import moore_stream_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bit_v,
    input  logic                   bit_last,
    input  logic                   det_z,
    input  logic                   clr_tot,
    output logic                   res_valid,
    output logic [$clog2(W+1)-1:0] res_count,
    output logic [TOT_W-1:0]       tot_hits
);

    localparam int CW = $clog2(W+1);

    logic          tag_v;
    logic          tag_last;
    logic [CW-1:0] acc;
    logic          hit;

    // A Z sample is only ours when it follows a cycle that drove a word bit
    assign hit = tag_v & det_z;

    // Delay the bit tags one cycle to line up with the detector's Moore output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v    <= 1'b0;
            tag_last <= 1'b0;
        end else begin
            tag_v    <= bit_v;
            tag_last <= bit_last;
        end
    end

    // Accumulate hits for the current word and publish them on its last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            res_valid <= 1'b0;
            res_count <= '0;
        end else begin
            res_valid <= 1'b0;
            if (tag_v && tag_last) begin
                res_count <= acc + {{(CW-1){1'b0}}, det_z};
                res_valid <= 1'b1;
                acc       <= '0;
            end else if (hit) begin
                acc <= acc + 1'b1;
            end
        end
    end

    // Saturating total of counted hits; a clear wins over a same-cycle hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tot_hits <= '0;
        end else if (clr_tot) begin
            tot_hits <= '0;
        end else if (hit) begin
            tot_hits <= sat_inc(tot_hits);
        end
    end

endmodule

// File: rtl/moore_stream_sched.sv
// rtl/moore_stream_sched.sv - word-to-serial scheduler feeding a Moore detector and tallying its hits
module moore_stream_sched
    import moore_stream_sched_pkg::*;
#(
    parameter int   W        = DEF_W,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [W-1:0]           in_data,
    output logic                   in_ready,
    output logic                   det_x,
    input  logic                   det_z,
    output logic                   res_valid,
    output logic [$clog2(W+1)-1:0] res_count,
    input  logic                   clr_tot,
    output logic [TOT_W-1:0]       tot_hits
);

    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    state_t        state;
    logic [W-1:0]  shreg;
    logic [IW-1:0] bit_idx;
    logic          hs;
    logic          bit_v;
    logic          bit_last;

    // Ready while idle, and on the final bit so the next word follows without a gap
    assign in_ready = (state == IDLE) | ((state == SHIFT) & (bit_idx == LAST_IDX));
    assign hs       = in_valid & in_ready;
    assign bit_v    = (state == SHIFT);
    assign bit_last = (state == SHIFT) & (bit_idx == LAST_IDX);

    // shreg holds the bits still waiting behind the one currently on det_x
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_idx <= '0;
            det_x   <= IDLE_BIT;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        det_x   <= in_data[W-1];
                        shreg   <= {in_data[W-2:0], 1'b0};
                        bit_idx <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_idx == LAST_IDX) begin
                        if (hs) begin
                            det_x   <= in_data[W-1];
                            shreg   <= {in_data[W-2:0], 1'b0};
                            bit_idx <= '0;
                        end else begin
                            det_x <= IDLE_BIT;
                            state <= IDLE;
                        end
                    end else begin
                        det_x   <= shreg[W-1];
                        shreg   <= shreg << 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
            endcase
        end
    end

    moore_stream_sched_hit_tally #(.W(W)) u_hit_tally (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_v     (bit_v),
        .bit_last  (bit_last),
        .det_z     (det_z),
        .clr_tot   (clr_tot),
        .res_valid (res_valid),
        .res_count (res_count),
        .tot_hits  (tot_hits)
    );

endmodule

// File: tb/tb_moore_stream_sched.sv
// tb/tb_moore_stream_sched.sv - scoreboard bench for the Moore detector stimulus scheduler
module tb_moore_stream_sched;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [W-1:0] in_data;
    logic        in_ready;
    logic        det_x;
    logic        det_z;
    logic        res_valid;
    logic [3:0]  res_count;
    logic        clr_tot;
    logic [15:0] tot_hits;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tot_exp = 0;

    typedef struct {
        int cnt;
        int tot;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    moore_stream_sched #(.W(W), .IDLE_BIT(1'b0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .det_x     (det_x),
        .det_z     (det_z),
        .res_valid (res_valid),
        .res_count (res_count),
        .clr_tot   (clr_tot),
        .tot_hits  (tot_hits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected actual=res_valid expected=none count=%0d", res_count);
            end else begin
                mon_e = q.pop_front();
                check("res_count", {28'd0, res_count}, mon_e.cnt);
                check("res_tot", {16'd0, tot_hits}, mon_e.tot);
                check("res_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected result of word w of a burst whose handshake cycle was hc
    task automatic push_exp(input int hc, input int w, input logic [7:0] m, input int clr_at);
        exp_t e;
        for (int j = 0; j < W; j++) begin
            if (w * W + j + 2 == clr_at) tot_exp = 0;
            else if (m[W-1-j] && tot_exp < 65535) tot_exp++;
        end
        e.cnt = $countones(m);
        e.tot = tot_exp;
        e.cyc = hc + w * W + W + 2;
        q.push_back(e);
    endtask

    // n back-to-back words: first d0/m0, rest dn/mn; mask MSB = first bit shifted
    task automatic burst(input int n, input logic [7:0] d0, input logic [7:0] dn,
                         input logic [7:0] m0, input logic [7:0] mn,
                         input logic prez, input int clr_at);
        int hc;
        int k;
        int p;
        logic [7:0] d;
        logic [7:0] pm;
        hc = cyc;
        check("burst_ready0", {31'd0, in_ready}, 1);
        in_valid = 1'b1;
        in_data  = d0;
        det_z    = 1'b0;
        clr_tot  = (clr_at == 0);
        push_exp(hc, 0, m0, clr_at);
        for (int w = 0; w < n; w++) begin
            d = (w == 0) ? d0 : dn;
            for (int b = 0; b < W; b++) begin
                step();
                k = w * W + b + 1;
                clr_tot = (k == clr_at);
                check("det_x_bit", {31'd0, det_x}, {31'd0, d[W-1-b]});
                check("in_ready_shift", {31'd0, in_ready}, (b == W - 1) ? 1 : 0);
                if (k == 1) begin
                    det_z = prez;
                end else begin
                    p  = k - 2;
                    pm = (p / W == 0) ? m0 : mn;
                    det_z = pm[W-1-(p % W)];
                end
                in_valid = (w < n - 1);
                if (w < n - 1) in_data = dn;
                if (b == W - 1 && w < n - 1) push_exp(hc, w + 1, mn, clr_at);
            end
        end
        step();
        k = n * W + 1;
        clr_tot = (k == clr_at);
        pm = (n == 1) ? m0 : mn;
        det_z = pm[0];
        in_valid = 1'b0;
        check("det_x_after", {31'd0, det_x}, 0);
        check("in_ready_after", {31'd0, in_ready}, 1);
        step();
        det_z   = 1'b0;
        clr_tot = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        det_z    = 1'b0;
        clr_tot  = 1'b0;
        repeat (2) step();

        check("rst_in_ready", {31'd0, in_ready}, 1);
        check("rst_det_x", {31'd0, det_x}, 0);
        check("rst_res_valid", {31'd0, res_valid}, 0);
        check("rst_res_count", {28'd0, res_count}, 0);
        check("rst_tot_hits", {16'd0, tot_hits}, 0);
        rst_n = 1'b1;
        step();

        // Single word, no hits
        burst(1, 8'hB5, 8'h00, 8'h00, 8'h00, 1'b0, -1);

        // Hits after bits 7, 5, 2; a pre-word Z pulse must be ignored
        burst(1, 8'h3C, 8'h00, 8'b1010_0100, 8'h00, 1'b1, -1);
        check("attr_tot", {16'd0, tot_hits}, 3);

        // Back-to-back FF then 00, hit on last bit of the first word
        burst(2, 8'hFF, 8'h00, 8'h01, 8'h00, 1'b0, -1);
        check("b2b_tot", {16'd0, tot_hits}, 4);

        // Stall gap with Z held high must not count
        burst(1, 8'hA6, 8'h00, 8'h81, 8'h00, 1'b0, -1);
        det_z = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_det_x", {31'd0, det_x}, 0);
            check("stall_ready", {31'd0, in_ready}, 1);
        end
        det_z = 1'b0;
        check("stall_tot", {16'd0, tot_hits}, 6);
        burst(1, 8'h5A, 8'h00, 8'h10, 8'h00, 1'b0, -1);

        // Reset in the middle of a word: discarded, no result
        in_valid = 1'b1;
        in_data  = 8'hC3;
        det_z    = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        tot_exp = 0;
        check("midrst_det_x", {31'd0, det_x}, 0);
        check("midrst_ready", {31'd0, in_ready}, 1);
        check("midrst_res_valid", {31'd0, res_valid}, 0);
        check("midrst_tot", {16'd0, tot_hits}, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            step();
            check("midrst_idle_x", {31'd0, det_x}, 0);
        end
        det_z = 1'b0;
        check("midrst_tot_after", {16'd0, tot_hits}, 0);

        // Saturation: 65534 hits, then 3 more
        clr_tot = 1'b1;
        step();
        clr_tot = 1'b0;
        tot_exp = 0;
        burst(8192, 8'hFF, 8'hFF, 8'h3F, 8'hFF, 1'b0, -1);
        check("sat_preload", {16'd0, tot_hits}, 32'hFFFE);
        burst(1, 8'h0F, 8'h00, 8'h07, 8'h00, 1'b0, -1);
        check("sat_max", {16'd0, tot_hits}, 32'hFFFF);

        // Clear in the same cycle as a hit wins
        burst(1, 8'h55, 8'h00, 8'h80, 8'h00, 1'b0, 2);
        check("clr_prio", {16'd0, tot_hits}, 0);

        repeat (3) step();
        check("sb_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
